// File: rtl/fft_pkg.sv
// Shared constants for the iterative FFT address path: FSM state encoding,
// butterflies-per-layer helper and the default butterfly datapath latency.
package fft_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

    localparam int LAT_DEFAULT = 3;

    // Butterflies per layer for a 2^awl point transform.
    function automatic int n_half(input int awl);
        return 1 << (awl - 1);
    endfunction

endpackage

// File: rtl/fft_addr_delay_line.sv
// LAT-stage shift register carrying {valid, a, b}. Only the valid bits are
// cleared by reset; address stages are plain data flops.
module fft_addr_delay_line #(
    parameter int AWL = 5,
    parameter int LAT = 3
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    input  logic [AWL-1:0] IN_A,
    input  logic [AWL-1:0] IN_B,
    output logic           OUT_VALID,
    output logic [AWL-1:0] OUT_A,
    output logic [AWL-1:0] OUT_B
);

    logic [LAT-1:0] vld_q;
    logic [AWL-1:0] a_q [LAT];
    logic [AWL-1:0] b_q [LAT];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= IN_VALID;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        a_q[0] <= IN_A;
        b_q[0] <= IN_B;
        for (int i = 1; i < LAT; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
        end
    end

    assign OUT_VALID = vld_q[LAT-1];
    assign OUT_A     = a_q[LAT-1];
    assign OUT_B     = b_q[LAT-1];

endmodule

// File: rtl/butterfly_writeback_ctrl.sv
// Replays butterfly read addresses as in-place write addresses after the
// datapath latency and holds off reads at each layer boundary until drained.
module butterfly_writeback_ctrl
    import fft_pkg::*;
#(
    parameter int AWL = 5,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            RD_VALID,
    output logic            RD_READY,
    input  logic [AWL-1:0]  RD_A_ADDR,
    input  logic [AWL-1:0]  RD_B_ADDR,
    output logic            LAY_EN,
    output logic            WR_EN,
    output logic [AWL-1:0]  WR_A_ADDR,
    output logic [AWL-1:0]  WR_B_ADDR,
    output logic            BUSY,
    output logic            LAY_DONE,
    output logic            FRAME_DONE,
    output logic [ST_W-1:0] DBG_STATE
);

    // Read handshake: a read transfers on RD_VALID & RD_READY; RD_READY is
    // high only in RUN and never depends on RD_VALID.

    localparam logic [AWL-1:0] HALF_M1  = AWL'(n_half(AWL) - 1);
    localparam logic [AWL-1:0] LAY_LAST = AWL'(AWL - 1);

    logic [ST_W-1:0] state;
    logic [AWL-1:0]  rd_cnt;
    logic [AWL-1:0]  wr_cnt;
    logic [AWL-1:0]  lay_cnt;

    logic            rd_xfer;
    logic            last_rd;
    logic            lay_end;
    logic            last_lay;
    logic            tail_v;
    logic [AWL-1:0]  tail_a;
    logic [AWL-1:0]  tail_b;

    fft_addr_delay_line #(
        .AWL (AWL),
        .LAT (LAT)
    ) u_delay (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (rd_xfer),
        .IN_A      (RD_A_ADDR),
        .IN_B      (RD_B_ADDR),
        .OUT_VALID (tail_v),
        .OUT_A     (tail_a),
        .OUT_B     (tail_b)
    );

    assign RD_READY = (state == ST_RUN);
    assign rd_xfer  = RD_VALID & RD_READY;
    assign last_rd  = rd_xfer && (rd_cnt == HALF_M1);
    assign lay_end  = tail_v && (wr_cnt == HALF_M1);
    assign last_lay = (lay_cnt == LAY_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            lay_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state   <= ST_RUN;
                        rd_cnt  <= '0;
                        wr_cnt  <= '0;
                        lay_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (last_rd) state <= ST_DRAIN;
                end
                ST_DRAIN: ;
                default: state <= ST_IDLE;
            endcase

            if (rd_xfer) rd_cnt <= rd_cnt + AWL'(1);
            if (tail_v)  wr_cnt <= wr_cnt + AWL'(1);

            // Layer boundary overrides the increments above: all reads of
            // the layer are already in, so no transfer can coincide with it.
            if (lay_end) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                if (last_lay) begin
                    state <= ST_IDLE;
                end else begin
                    lay_cnt <= lay_cnt + AWL'(1);
                    state   <= ST_RUN;
                end
            end
        end
    end

    // Address stages are not reset, so gate them to keep outputs at 0 when idle.
    assign WR_EN      = tail_v;
    assign WR_A_ADDR  = tail_v ? tail_a : '0;
    assign WR_B_ADDR  = tail_v ? tail_b : '0;
    assign LAY_DONE   = lay_end;
    assign LAY_EN     = lay_end;
    assign FRAME_DONE = lay_end & last_lay;
    assign BUSY       = (state != ST_IDLE);
    assign DBG_STATE  = state;

endmodule

// File: tb/tb_butterfly_writeback_ctrl.sv
// Randomized bench for butterfly_writeback_ctrl against a timestamp-based
// model: each accepted read is due back as a write exactly LAT cycles later.
module tb_butterfly_writeback_ctrl;
    import fft_pkg::*;

    localparam int AWL = 3;
    localparam int LAT = 3;
    localparam int NH  = 4;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            START = 1'b0;
    logic            RD_VALID = 1'b0;
    logic [AWL-1:0]  RD_A_ADDR = '0;
    logic [AWL-1:0]  RD_B_ADDR = '0;
    logic            RD_READY;
    logic            LAY_EN;
    logic            WR_EN;
    logic [AWL-1:0]  WR_A_ADDR;
    logic [AWL-1:0]  WR_B_ADDR;
    logic            BUSY;
    logic            LAY_DONE;
    logic            FRAME_DONE;
    logic [ST_W-1:0] DBG_STATE;

    butterfly_writeback_ctrl #(
        .AWL (AWL),
        .LAT (LAT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .RD_VALID   (RD_VALID),
        .RD_READY   (RD_READY),
        .RD_A_ADDR  (RD_A_ADDR),
        .RD_B_ADDR  (RD_B_ADDR),
        .LAY_EN     (LAY_EN),
        .WR_EN      (WR_EN),
        .WR_A_ADDR  (WR_A_ADDR),
        .WR_B_ADDR  (WR_B_ADDR),
        .BUSY       (BUSY),
        .LAY_DONE   (LAY_DONE),
        .FRAME_DONE (FRAME_DONE),
        .DBG_STATE  (DBG_STATE)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard and reference model state
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit m_active = 1'b0;
    int m_rd = 0;
    int m_wr = 0;
    int m_lay = 0;
    logic [2*AWL-1:0] exp_q[$];
    int due_q[$];
    int wr_seen = 0;
    int lay_seen = 0;
    int fd_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One cycle: compare outputs to the model, drive inputs, advance the model.
    task automatic step(input logic start, input logic vld, input logic [AWL-1:0] a,
                        input logic [AWL-1:0] b, input logic rst_low);
        logic e_wr, e_rdy, e_lay, e_frame;
        logic [2*AWL-1:0] e_ab;
        bit was_active;
        @(negedge CLK);
        e_wr    = (due_q.size() > 0) && (due_q[0] == cyc);
        e_ab    = e_wr ? exp_q[0] : '0;
        e_rdy   = m_active && (m_rd < NH);
        e_lay   = e_wr && (m_wr == NH - 1);
        e_frame = e_lay && (m_lay == AWL - 1);
        check_eq("rd_ready",   32'(RD_READY),   32'(e_rdy));
        check_eq("busy",       32'(BUSY),       32'(m_active));
        check_eq("wr_en",      32'(WR_EN),      32'(e_wr));
        check_eq("wr_addr",    32'({WR_A_ADDR, WR_B_ADDR}), 32'(e_ab));
        check_eq("lay_done",   32'(LAY_DONE),   32'(e_lay));
        check_eq("lay_en",     32'(LAY_EN),     32'(e_lay));
        check_eq("frame_done", 32'(FRAME_DONE), 32'(e_frame));
        check_eq("state_idle", 32'(DBG_STATE == ST_IDLE), 32'(!m_active));
        if (WR_EN)      wr_seen++;
        if (LAY_EN)     lay_seen++;
        if (FRAME_DONE) fd_seen++;

        START     = start;
        RD_VALID  = vld;
        RD_A_ADDR = a;
        RD_B_ADDR = b;
        RST_N     = !rst_low;

        if (rst_low) begin
            m_active = 1'b0;
            m_rd = 0;
            m_wr = 0;
            m_lay = 0;
            exp_q.delete();
            due_q.delete();
        end else begin
            was_active = m_active;
            if (e_wr) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
                m_wr++;
            end
            if (e_rdy && vld) begin
                exp_q.push_back({a, b});
                due_q.push_back(cyc + LAT);
                m_rd++;
            end
            if (e_lay) begin
                m_rd = 0;
                m_wr = 0;
                if (m_lay == AWL - 1) m_active = 1'b0;
                else m_lay++;
            end
            if (!was_active && start) begin
                m_active = 1'b1;
                m_rd = 0;
                m_wr = 0;
                m_lay = 0;
            end
        end
        cyc++;
    endtask

    // Driver: pick one cycle's read-side stimulus for a given pattern.
    task automatic drive_cycle(input int mode);
        logic vld, st;
        logic [AWL-1:0] a, b;
        st = 1'b0;
        case (mode)
            0: begin
                vld = 1'b1;
                a = AWL'(2 * (m_rd % NH));
                b = a + AWL'(1);
            end
            1: begin
                vld = (cyc % 2 == 0);
                a = AWL'($urandom_range(0, 7));
                b = AWL'($urandom_range(0, 7));
            end
            default: begin
                vld = 1'($urandom_range(0, 1));
                st  = ($urandom_range(0, 4) == 0);
                a = AWL'($urandom_range(0, 7));
                b = AWL'($urandom_range(0, 7));
            end
        endcase
        step(st, vld, a, b, 1'b0);
    endtask

    task automatic run_frame(input int mode);
        int budget;
        wr_seen = 0;
        lay_seen = 0;
        fd_seen = 0;
        step(1'b1, 1'b0, '0, '0, 1'b0);
        budget = 0;
        while ((m_active || due_q.size() > 0) && budget < 400) begin
            drive_cycle(mode);
            budget++;
        end
        check_eq("frame_timeout", 32'(budget < 400), 32'd1);
        check_eq("frame_writes",  32'(wr_seen),  32'(AWL * NH));
        check_eq("frame_lay_en",  32'(lay_seen), 32'(AWL));
        check_eq("frame_done_n",  32'(fd_seen),  32'd1);
        // Idle with reads offered: nothing may be captured.
        wr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), AWL'($urandom_range(0, 7)),
                 AWL'($urandom_range(0, 7)), 1'b0);
        end
        check_eq("idle_writes", 32'(wr_seen), 32'd0);
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, '0, 1'b0);

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(2);

        // Reset in layer 1 while two writes are still in flight.
        step(1'b1, 1'b0, '0, '0, 1'b0);
        budget = 0;
        while (!(m_lay == 1 && due_q.size() == 2) && budget < 100) begin
            drive_cycle(0);
            budget++;
        end
        check_eq("reset_point_reached", 32'(budget < 100), 32'd1);
        step(1'b0, 1'b1, '0, '0, 1'b1);
        step(1'b0, 1'b1, '0, '0, 1'b1);
        wr_seen = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd5, 3'd6, 1'b0);
        check_eq("post_reset_writes", 32'(wr_seen), 32'd0);

        run_frame(0);
        run_frame(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
